vram_arbiter: RTL

- Sequences the single external 8-bit SRAM between the video fetch path and a host pixel read/write port.
- Runs a fixed 4-clock slot per framebuffer byte; each byte spans 2 pixel clocks at 2x-clock pixel rate.
- Video owns phases 0-1 during active display; the host owns phases 2-3 always, and phases 0-1 during blanking.
- Host writes are posted through a small FIFO; host reads stall until the FIFO drains.

---
 rtl/vram_pkg.sv | 33 +++
 rtl/vram_write_fifo.sv | 51 +++++
 rtl/vram_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared types and helpers for the VRAM arbiter.
package vram_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;

  typedef enum logic [1:0] {
    PH_VADDR = 2'd0,
    PH_VDATA = 2'd1,
    PH_HADDR = 2'd2,
    PH_HDATA = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_VIDEO  = 2'd1,
    OWN_HWRITE = 2'd2,
    OWN_HREAD  = 2'd3
  } owner_e;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } pwrite_t;

  // y*320 + x built from shifts; fits 17 bits for in-range coordinates.
  function automatic logic [16:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
    logic [16:0] yy;
    yy = {9'd0, y};
    return (yy << 8) + (yy << 6) + {8'd0, x};
  endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Posted-write FIFO: synchronous push/pop, registered level, async active-low reset.
module vram_write_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  vram_pkg::pwrite_t       i_data,
  input  logic                    i_pop,
  output vram_pkg::pwrite_t       o_head,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_full,
  output logic                    o_empty
);
  import vram_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  pwrite_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr];
  assign o_level   = r_level;

  // Storage, pointers and level; simultaneous push and pop keeps the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slots the single 8-bit SRAM between video fetch and the host port.
module vram_arbiter #(
  parameter int unsigned FB_WIDTH         = vram_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT        = vram_pkg::FB_HEIGHT,
  parameter int unsigned WRITE_FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH       = 17
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [8:0]                          videoXCoord,
  input  logic [7:0]                          videoYCoord,
  input  logic                                videoActive,
  output logic [7:0]                          videoData,
  output logic                                videoDataReady,
  input  logic                                hostReq,
  input  logic                                hostWrite,
  input  logic [8:0]                          hostXCoord,
  input  logic [7:0]                          hostYCoord,
  input  logic [7:0]                          hostWriteData,
  output logic                                hostAck,
  output logic [7:0]                          hostReadData,
  output logic [ADDR_WIDTH-1:0]               ramAddress,
  output logic [7:0]                          ramDataOut,
  output logic                                ramDataDrive,
  input  logic [7:0]                          ramDataIn,
  output logic                                ramOutputEnable,
  output logic                                ramWriteEnable,
  output logic [1:0]                          slotPhase,
  output logic [$clog2(WRITE_FIFO_DEPTH):0]   fifoLevel
);
  import vram_pkg::*;

  localparam int unsigned LW = $clog2(WRITE_FIFO_DEPTH) + 1;

  phase_e          r_phase;
  logic            r_video_slot;
  logic [16:0]     r_vaddr;
  owner_e          r_howner;
  logic [7:0]      r_vdata;
  logic            r_vstrobe;
  logic            r_ack;
  logic [7:0]      r_hrdata;
  logic            r_rd_pend;
  logic [16:0]     r_rd_addr;

  pwrite_t         w_head;
  logic [LW-1:0]   w_level;
  logic            w_full;
  logic            w_empty;
  logic [16:0]     w_vaddr;
  logic [16:0]     w_haddr;
  logic            w_hinrange;
  owner_e          w_owner;
  logic            w_host_first;
  logic            w_host_second;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_rd_done;

  assign w_vaddr       = fb_addr(videoXCoord, videoYCoord);
  assign w_haddr       = fb_addr(hostXCoord, hostYCoord);
  assign w_hinrange    = (32'(hostXCoord) < FB_WIDTH) && (32'(hostYCoord) < FB_HEIGHT);
  assign w_host_first  = (r_phase == PH_HADDR) || ((r_phase == PH_VADDR) && !videoActive);
  assign w_host_second = (r_phase == PH_HDATA) || ((r_phase == PH_VDATA) && !r_video_slot);
  assign w_accept      = hostReq && !r_ack && !r_rd_pend && (!hostWrite || !w_full);
  assign w_push        = w_accept && hostWrite && w_hinrange;
  assign w_pop         = (w_owner == OWN_HWRITE) && w_host_second;
  assign w_rd_done     = (w_owner == OWN_HREAD) && w_host_second;

  vram_write_fifo #(.DEPTH(WRITE_FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  ('{addr: w_haddr, data: hostWriteData}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Slot owner for the current cycle; forced idle while reset is low so strobes drop at once.
  always_comb begin
    w_owner = OWN_IDLE;
    if (!reset) begin
      w_owner = OWN_IDLE;
    end else if ((r_phase == PH_VADDR) && videoActive) begin
      w_owner = OWN_VIDEO;
    end else if ((r_phase == PH_VDATA) && r_video_slot) begin
      w_owner = OWN_VIDEO;
    end else if (w_host_first) begin
      if (!w_empty)       w_owner = OWN_HWRITE;
      else if (r_rd_pend) w_owner = OWN_HREAD;
    end else if (w_host_second) begin
      w_owner = r_howner;
    end
  end

  // SRAM pin drive decoded from the owner.
  always_comb begin
    ramAddress      = '0;
    ramDataOut      = '0;
    ramDataDrive    = 1'b0;
    ramOutputEnable = 1'b0;
    ramWriteEnable  = 1'b0;
    case (w_owner)
      OWN_VIDEO: begin
        ramOutputEnable = 1'b1;
        ramAddress      = (r_phase == PH_VADDR) ? ADDR_WIDTH'(w_vaddr) : ADDR_WIDTH'(r_vaddr);
      end
      OWN_HWRITE: begin
        ramAddress     = ADDR_WIDTH'(w_head.addr);
        ramDataOut     = w_head.data;
        ramDataDrive   = 1'b1;
        ramWriteEnable = w_host_first;
      end
      OWN_HREAD: begin
        ramOutputEnable = 1'b1;
        ramAddress      = ADDR_WIDTH'(r_rd_addr);
      end
      default: ;
    endcase
  end

  // Slot counter, video slot decision and video byte capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase      <= PH_VADDR;
      r_video_slot <= 1'b0;
      r_vaddr      <= '0;
      r_howner     <= OWN_IDLE;
      r_vdata      <= '0;
      r_vstrobe    <= 1'b0;
    end else begin
      r_phase   <= phase_e'(r_phase + 2'd1);
      r_vstrobe <= (w_owner == OWN_VIDEO) && (r_phase == PH_VDATA);
      if (r_phase == PH_VADDR) begin
        r_video_slot <= videoActive;
        r_vaddr      <= w_vaddr;
      end
      if (w_host_first) r_howner <= w_owner;
      if ((w_owner == OWN_VIDEO) && (r_phase == PH_VDATA)) r_vdata <= ramDataIn;
    end
  end

  // Host acceptance, pending read and ack strobe; the ack cycle blocks re-sampling hostReq.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ack     <= 1'b0;
      r_hrdata  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_ack <= 1'b0;
      if (w_rd_done) begin
        r_hrdata  <= ramDataIn;
        r_ack     <= 1'b1;
        r_rd_pend <= 1'b0;
      end else if (w_accept) begin
        if (hostWrite) begin
          r_ack <= 1'b1;
        end else if (!w_hinrange) begin
          r_hrdata <= '0;
          r_ack    <= 1'b1;
        end else begin
          r_rd_pend <= 1'b1;
          r_rd_addr <= w_haddr;
        end
      end
    end
  end

  assign videoData      = r_vdata;
  assign videoDataReady = r_vstrobe;
  assign hostAck        = r_ack;
  assign hostReadData   = r_hrdata;
  assign slotPhase      = r_phase;
  assign fifoLevel      = w_level;

endmodule
